wall_renderer: RTL and testbench
================================

WALL_RENDERER -- requirements
Module: wall_renderer

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, number of stored columns.
REQ-002 SHALL have parameter HALF_H, default 240, screen vertical midline (row index).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port store  input  1  write strobe from tracer.
REQ-006 SHALL have port column  input  10  write address (column).
REQ-007 SHALL have port side  input  1  wall side for written column.
REQ-008 SHALL have port height  input  8  half-height for written column, legal 0..240.
REQ-009 SHALL have port hpos  input  10  current display column.
REQ-010 SHALL have port vpos  input  10  current display row.
REQ-011 SHALL have port visible  input  1  high inside the 640x480 active area.
REQ-012 SHALL have port frame_start  input  1  one-cycle pulse at start of each frame's VBLANK.
REQ-013 SHALL have port rgb  output  6  pixel colour {R[1:0],G[1:0],B[1:0]}, registered.
REQ-014 SHALL have port frame_complete  output  1  high once all SCREEN_W columns are written since last frame_start.

Function
REQ-015 SHALL hold a SCREEN_W x 9-bit column buffer {side, height}; no reset of buffer contents.
REQ-016 SHALL write {side,height} to entry column on any cycle with store=1 and column<SCREEN_W; column>=SCREEN_W ignored.
REQ-017 SHALL accept writes regardless of visible; write to an address being read in the same cycle -> read returns old contents.
REQ-018 SHALL implement a 2-stage read pipeline: stage 1 registers buffer[hpos], vpos, visible; stage 2 computes and registers rgb.
REQ-019 SHALL produce rgb for a given (hpos,vpos,visible) exactly 2 cycles after it is presented.
REQ-020 SHALL treat hpos>=SCREEN_W as not visible (rgb=0).
REQ-021 SHALL output rgb=6'b000000 when the delayed visible=0.
REQ-022 SHALL classify visible pixel as wall when HALF_H-height <= vpos < HALF_H+height, computed in 11-bit unsigned arithmetic with no wrap; height=0 -> never wall.
REQ-023 SHALL colour wall pixels 6'b000011 when side=0 and 6'b000010 when side=1.
REQ-024 SHALL colour non-wall pixels with vpos<HALF_H as 6'b010101 (ceiling), else 6'b101010 (floor).
REQ-025 SHALL clamp stored height>240 to 240 at comparison time.
REQ-026 SHALL implement a 2-state write tracker FILLING/COMPLETE with 10-bit counter wr_count.
REQ-027 SHALL, in FILLING, increment wr_count on each accepted write; on wr_count reaching SCREEN_W-1 with an accepted write, go to COMPLETE.
REQ-028 SHALL count every accepted write, including repeated writes to the same column (no per-column tracking).
REQ-029 SHALL, in COMPLETE, ignore further writes for counting and hold wr_count.
REQ-030 SHALL, on frame_start from either state, set wr_count=0 and state FILLING; frame_start coincident with store -> write stored in buffer but not counted.
REQ-031 SHALL drive frame_complete=1 exactly when state is COMPLETE (registered, asserted the cycle after the final write).

Reset
REQ-032 SHALL, on reset_n=0 at clk edge: rgb=0, pipeline visible flags=0, wr_count=0, state FILLING, frame_complete=0.
REQ-033 SHALL ignore store and frame_start while reset_n=0; reset mid-frame discards count but not buffer contents.
REQ-034 SHALL produce rgb=0 for the first 2 cycles after reset release regardless of inputs.

Verification
REQ-035 Write col 100 {side=0,height=50}; present hpos=100, vpos=190/289/290/189, visible=1 -> rgb 6'b000011, 000011, 101010, 010101, each 2 cycles later.
REQ-036 Write col 5 {side=1,height=240}; vpos=0 and 479 -> 6'b000010 both; height=0 at col 6, vpos=239/240 -> 010101/101010.
REQ-037 frame_start then 640 writes cols 0..639 -> frame_complete rises the cycle after 640th write; further writes keep it high; next frame_start -> 0 next cycle.
REQ-038 Write column=700 and visible=1 with hpos=650 -> no count increment, rgb=0.
REQ-039 Same-cycle write and read of col 20 (old height 10, new 100), vpos=200 -> first rgb ceiling 010101, repeat read -> wall.
REQ-040 Assert reset_n=0 after 300 writes -> frame_complete=0, count restarts; buffer entry previously written still renders correctly.

Source files
------------

// File: rtl/wall_renderer.sv
// rtl/wall_renderer.sv - column-buffered wall renderer with frame write tracker
//
// Purpose:
//   Keeps one {side, half-height} entry per screen column. The ray tracer fills
//   it through a write port. A two-stage read pipeline follows the display beam
//   and turns each (hpos, vpos) into a wall, ceiling or floor colour. A small
//   tracker counts accepted writes so the tracer can tell when the frame's
//   column set is complete.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   reset_n        synchronous active-low reset
//   store          write strobe from the tracer
//   column[9:0]    write address; addresses >= SCREEN_W are dropped
//   side           wall side of the written column
//   height[7:0]    wall half-height of the written column (values above 240 clamp)
//   hpos[9:0]      display column being scanned
//   vpos[9:0]      display row being scanned
//   visible        high inside the active display area
//   frame_start    one-cycle pulse at the start of VBLANK
//   rgb[5:0]       registered pixel colour {R[1:0],G[1:0],B[1:0]}, 2-cycle latency
//   frame_complete high while SCREEN_W writes have been counted since frame_start

module wall_renderer #(
  parameter int SCREEN_W = 640,
  parameter int HALF_H   = 240
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       store,
  input  logic [9:0] column,
  input  logic       side,
  input  logic [7:0] height,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       visible,
  input  logic       frame_start,
  output logic [5:0] rgb,
  output logic       frame_complete
);

  localparam logic [10:0] SCREEN_W_11 = 11'(SCREEN_W);
  localparam logic [10:0] HALF_H_11   = 11'(HALF_H);
  localparam logic [9:0]  LAST_COUNT  = 10'(SCREEN_W - 1);
  localparam logic [7:0]  MAX_HEIGHT  = 8'd240;

  localparam logic [5:0] COLOUR_SIDE0   = 6'b000011;
  localparam logic [5:0] COLOUR_SIDE1   = 6'b000010;
  localparam logic [5:0] COLOUR_CEILING = 6'b010101;
  localparam logic [5:0] COLOUR_FLOOR   = 6'b101010;

  typedef enum logic {
    FILLING  = 1'b0,
    COMPLETE = 1'b1
  } trackState_t;

  // Column buffer: bit 8 = side, bits 7:0 = half-height. Never reset, so a
  // reset mid-frame leaves the last rendered picture intact.
  logic [8:0] columnBuf [SCREEN_W];

  logic writeAccept;
  logic hposInRange;

  assign writeAccept = store && ({1'b0, column} < SCREEN_W_11);
  assign hposInRange = {1'b0, hpos} < SCREEN_W_11;

  always_ff @(posedge clk) begin
    if (reset_n && writeAccept) begin
      columnBuf[column] <= {side, height};
    end
  end

  // Stage 1: fetch the column entry and delay the beam position alongside it.
  // The non-blocking read sees the entry as it was before any same-cycle write.
  logic [8:0] s1Entry;
  logic [9:0] s1Vpos;
  logic       s1Visible;

  always_ff @(posedge clk) begin
    if (hposInRange) begin
      s1Entry <= columnBuf[hpos];
    end
    s1Vpos <= vpos;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1Visible <= 1'b0;
    end else begin
      // Columns past the buffer are blanked here so stage 2 never looks at a
      // stale entry for them.
      s1Visible <= visible && hposInRange;
    end
  end

  // Stage 2: classify the pixel against the wall span [HALF_H-h, HALF_H+h).
  logic [7:0]  clampedHeight;
  logic [10:0] heightExt;
  logic [10:0] wallTop;
  logic [10:0] wallBottom;
  logic [10:0] vposExt;
  logic        isWall;
  logic [5:0]  pixelColour;

  always_comb begin
    clampedHeight = (s1Entry[7:0] > MAX_HEIGHT) ? MAX_HEIGHT : s1Entry[7:0];
    heightExt     = {3'b000, clampedHeight};
    // Saturate the top edge at row 0 so a short midline cannot wrap around.
    wallTop       = (heightExt > HALF_H_11) ? 11'd0 : (HALF_H_11 - heightExt);
    wallBottom    = HALF_H_11 + heightExt;
    vposExt       = {1'b0, s1Vpos};
    isWall        = (clampedHeight != 8'd0) && (vposExt >= wallTop) &&
                    (vposExt < wallBottom);

    pixelColour = 6'b000000;
    if (s1Visible) begin
      if (isWall) begin
        pixelColour = s1Entry[8] ? COLOUR_SIDE1 : COLOUR_SIDE0;
      end else if (vposExt < HALF_H_11) begin
        pixelColour = COLOUR_CEILING;
      end else begin
        pixelColour = COLOUR_FLOOR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rgb <= 6'b000000;
    end else begin
      rgb <= pixelColour;
    end
  end

  // Write tracker. Counts accepted writes, not distinct columns, so a tracer
  // that rewrites a column still advances the count.
  trackState_t state;
  logic [9:0]  wr_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= FILLING;
      wr_count       <= 10'd0;
      frame_complete <= 1'b0;
    end else if (frame_start) begin
      // A write landing on the frame_start cycle still reaches the buffer
      // above but belongs to the previous frame for counting purposes.
      state          <= FILLING;
      wr_count       <= 10'd0;
      frame_complete <= 1'b0;
    end else begin
      case (state)
        FILLING: begin
          if (writeAccept) begin
            wr_count <= wr_count + 10'd1;
            if (wr_count == LAST_COUNT) begin
              state          <= COMPLETE;
              frame_complete <= 1'b1;
            end
          end
        end
        COMPLETE: begin
          frame_complete <= 1'b1;
        end
        default: begin
          state          <= FILLING;
          frame_complete <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wall_renderer.sv
// tb/tb_wall_renderer.sv - scoreboard bench for wall_renderer

module tb_wall_renderer;

  localparam logic [5:0] SIDE0 = 6'b000011;
  localparam logic [5:0] SIDE1 = 6'b000010;
  localparam logic [5:0] CEIL  = 6'b010101;
  localparam logic [5:0] FLOOR = 6'b101010;
  localparam logic [5:0] BLACK = 6'b000000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       store;
  logic [9:0] column;
  logic       side;
  logic [7:0] height;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       visible;
  logic       frame_start;
  logic [5:0] rgb;
  logic       frame_complete;

  int checks = 0;
  int errors = 0;

  bit         chkQ [$];
  logic [5:0] expQ [$];
  string      tagQ [$];

  wall_renderer #(.SCREEN_W(640), .HALF_H(240)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .store         (store),
    .column        (column),
    .side          (side),
    .height        (height),
    .hpos          (hpos),
    .vpos          (vpos),
    .visible       (visible),
    .frame_start   (frame_start),
    .rgb           (rgb),
    .frame_complete(frame_complete)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, got, exp);
    end
  endtask

  // One clock: the current inputs are sampled at the edge and their expected
  // rgb queued; the entry queued on the previous edge is due now.
  task automatic tick(input bit chk, input logic [5:0] exp, input string tag);
    bit         c;
    logic [5:0] e;
    string      t;
    @(posedge clk);
    chkQ.push_back(chk);
    expQ.push_back(exp);
    tagQ.push_back(tag);
    #1;
    if (chkQ.size() > 1) begin
      c = chkQ.pop_front();
      e = expQ.pop_front();
      t = tagQ.pop_front();
      if (c) check(t, rgb, e);
    end
  endtask

  task automatic write_col(input int col, input logic s, input logic [7:0] h);
    store  = 1'b1;
    column = 10'(col);
    side   = s;
    height = h;
    tick(1'b0, BLACK, "write");
    store  = 1'b0;
  endtask

  task automatic pixel(input int h, input int v, input logic vis,
                       input logic [5:0] exp, input string tag);
    hpos    = 10'(h);
    vpos    = 10'(v);
    visible = vis;
    tick(1'b1, exp, tag);
    visible = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    store       = 1'b0;
    column      = 10'd0;
    side        = 1'b0;
    height      = 8'd0;
    hpos        = 10'd100;
    vpos        = 10'd200;
    visible     = 1'b1;
    frame_start = 1'b0;

    // Reset: rgb must be black even with visible pixels presented.
    tick(1'b1, BLACK, "reset_rgb0");
    tick(1'b1, BLACK, "reset_rgb1");
    tick(1'b1, BLACK, "reset_rgb2");
    check("reset_fc", {5'd0, frame_complete}, 6'd0);

    reset_n = 1'b1;
    visible = 1'b0;
    tick(1'b1, BLACK, "post_reset");

    // Basic wall span for half-height 50: rows 190..289.
    write_col(100, 1'b0, 8'd50);
    pixel(100, 190, 1'b1, SIDE0, "c100_v190");
    pixel(100, 289, 1'b1, SIDE0, "c100_v289");
    pixel(100, 290, 1'b1, FLOOR, "c100_v290");
    pixel(100, 189, 1'b1, CEIL,  "c100_v189");
    pixel(100, 200, 1'b0, BLACK, "not_visible");

    // Full-height, zero-height and clamped-height columns.
    write_col(5, 1'b1, 8'd240);
    write_col(6, 1'b0, 8'd0);
    write_col(7, 1'b0, 8'd255);
    pixel(5, 0,   1'b1, SIDE1, "c5_v0");
    pixel(5, 479, 1'b1, SIDE1, "c5_v479");
    pixel(6, 239, 1'b1, CEIL,  "c6_v239");
    pixel(6, 240, 1'b1, FLOOR, "c6_v240");
    pixel(7, 0,   1'b1, SIDE0, "clamp_v0");
    pixel(7, 479, 1'b1, SIDE0, "clamp_v479");
    pixel(650, 200, 1'b1, BLACK, "hpos_650");

    // Same-cycle write and read returns the old entry.
    write_col(20, 1'b0, 8'd10);
    store  = 1'b1;
    column = 10'd20;
    side   = 1'b0;
    height = 8'd100;
    pixel(20, 200, 1'b1, CEIL, "rw_same_old");
    store  = 1'b0;
    pixel(20, 200, 1'b1, SIDE0, "rw_same_new");

    // Frame 1: 640 writes with an out-of-range write in the middle.
    frame_start = 1'b1;
    tick(1'b0, BLACK, "fs1");
    frame_start = 1'b0;
    check("fc_after_fs1", {5'd0, frame_complete}, 6'd0);
    for (int i = 0; i < 640; i++) begin
      if (i == 320) begin
        store   = 1'b1;
        column  = 10'd700;
        height  = 8'd33;
        hpos    = 10'd650;
        vpos    = 10'd100;
        visible = 1'b1;
        tick(1'b1, BLACK, "col700_rgb");
        visible = 1'b0;
        store   = 1'b0;
      end
      write_col(i, 1'(i % 2), 8'(i % 200));
      if (i == 638) check("fc_before_last", {5'd0, frame_complete}, 6'd0);
    end
    check("fc_rise", {5'd0, frame_complete}, 6'd1);
    write_col(0, 1'b0, 8'd0);
    check("fc_hold", {5'd0, frame_complete}, 6'd1);

    // Frame 2: write coincident with frame_start is stored, not counted.
    frame_start = 1'b1;
    store       = 1'b1;
    column      = 10'd620;
    side        = 1'b1;
    height      = 8'd60;
    tick(1'b0, BLACK, "fs2");
    frame_start = 1'b0;
    store       = 1'b0;
    check("fc_clear", {5'd0, frame_complete}, 6'd0);
    pixel(620, 200, 1'b1, SIDE1, "fs_write_stored");
    for (int i = 0; i < 639; i++) write_col(639, 1'b0, 8'd0);
    check("fc_repeat_639", {5'd0, frame_complete}, 6'd0);
    write_col(639, 1'b0, 8'd0);
    check("fc_repeat_640", {5'd0, frame_complete}, 6'd1);

    // Frame 3: reset after 300 writes discards the count, keeps the buffer.
    frame_start = 1'b1;
    tick(1'b0, BLACK, "fs3");
    frame_start = 1'b0;
    for (int i = 0; i < 300; i++) write_col(639, 1'b0, 8'd0);
    reset_n = 1'b0;
    tick(1'b0, BLACK, "mid_reset");
    reset_n = 1'b1;
    check("fc_mid_reset", {5'd0, frame_complete}, 6'd0);
    for (int i = 0; i < 639; i++) write_col(639, 1'b0, 8'd0);
    check("fc_restart_639", {5'd0, frame_complete}, 6'd0);
    write_col(639, 1'b0, 8'd0);
    check("fc_restart_640", {5'd0, frame_complete}, 6'd1);
    pixel(620, 200, 1'b1, SIDE1, "buf_kept_wall");
    pixel(620, 120, 1'b1, CEIL,  "buf_kept_ceil");
    pixel(100, 400, 1'b1, FLOOR, "buf_kept_floor");
    tick(1'b0, BLACK, "drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
